data_ram_arbiter: RTL

//  Two-port arbiter and sequencer in front of the single-port data RAM (C x 2**AD).

---
 rtl/data_ram_arbiter_pkg.sv | 27 ++
 rtl/data_ram_arbiter_if.sv | 51 +++++
 rtl/data_ram_arbiter_rr.sv | 51 +++++
 rtl/data_ram_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/data_ram_arbiter_pkg.sv
// Shared constants and types for the data RAM arbiter slice.
// Optional build macro: DATA_RAM_ARB_FIXED_PRIO_EN (fixed priority to A instead of round-robin).
package data_ram_pkg;

    localparam int C_DEF  = 32;
    localparam int AD_DEF = 5;
    localparam int DEPTH  = 2 ** AD_DEF;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_SERVE = 1'b1;

    typedef enum logic {
        S_CLEAR = ST_CLEAR,
        S_SERVE = ST_SERVE
    } state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

    // Row that follows 'row'; the counter wraps naturally at the top row.
    function automatic logic [AD_DEF-1:0] next_row(input logic [AD_DEF-1:0] row);
        return row + 1'b1;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Bundle of requester A/B, read-return and RAM-port signals around the arbiter.
// master = requesters plus RAM model side, slave = the arbiter itself.
interface data_ram_arbiter_if
    import data_ram_pkg::*;
#(
    parameter int C  = C_DEF,
    parameter int AD = AD_DEF
);

    logic          req_a;
    logic          wr_a;
    logic [AD-1:0] addr_a;
    logic [C-1:0]  din_a;
    logic          gnt_a;
    logic          rvalid_a;

    logic          req_b;
    logic          wr_b;
    logic [AD-1:0] addr_b;
    logic [C-1:0]  din_b;
    logic          gnt_b;
    logic          rvalid_b;

    logic [C-1:0]  rdata;
    logic          busy;

    logic [C-1:0]  ram_din;
    logic [AD-1:0] ram_addr;
    logic          ram_wr;
    logic          ram_en;
    logic [C-1:0]  ram_dout;

    modport master (
        output req_a, wr_a, addr_a, din_a,
        output req_b, wr_b, addr_b, din_b,
        output ram_dout,
        input  gnt_a, rvalid_a, gnt_b, rvalid_b,
        input  rdata, busy,
        input  ram_din, ram_addr, ram_wr, ram_en
    );

    modport slave (
        input  req_a, wr_a, addr_a, din_a,
        input  req_b, wr_b, addr_b, din_b,
        input  ram_dout,
        output gnt_a, rvalid_a, gnt_b, rvalid_b,
        output rdata, busy,
        output ram_din, ram_addr, ram_wr, ram_en
    );

endinterface

// File: rtl/data_ram_arbiter_rr.sv
// Two-way grant logic for the data RAM: round-robin by default,
// fixed priority to A when DATA_RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2
    import data_ram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic gnt_a,
    output logic gnt_b
);

`ifdef DATA_RAM_ARB_FIXED_PRIO_EN

    // No pointer state in this build; these inputs are intentionally ignored.
    logic unused_sigs;
    assign unused_sigs = ^{clk, rst, advance};

    assign gnt_a = req_a;
    assign gnt_b = req_b & ~req_a;

`else

    side_t rr_ptr_reg;
    side_t rr_ptr_next;

    // Grants depend only on requests and the pointer, never on advance,
    // so the advance feedback from the top cannot form a combinational loop.
    assign gnt_a = req_a & (~req_b | (rr_ptr_reg == SIDE_A));
    assign gnt_b = req_b & ~gnt_a;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (advance) begin
            rr_ptr_next = gnt_a ? SIDE_B : SIDE_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= SIDE_A;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

`endif

endmodule

// File: rtl/data_ram_arbiter.sv
// Clears the single-port data RAM after reset, then shares it between A and B.
// Grant policy is selected by DATA_RAM_ARB_FIXED_PRIO_EN inside rr_arbiter2.
module data_ram_arbiter
    import data_ram_pkg::*;
#(
    parameter int C  = C_DEF,
    parameter int AD = AD_DEF
)(
    input  logic                clk,
    input  logic                rst,
    data_ram_arbiter_if.slave   bus
);

    localparam logic [AD-1:0] LAST_ROW = {AD{1'b1}};

    state_t        state_reg;
    state_t        state_next;
    logic [AD-1:0] clr_addr_reg;
    logic [AD-1:0] clr_addr_next;

    logic [AD-1:0] hold_addr_reg;
    logic [C-1:0]  hold_din_reg;
    logic          hold_wr_reg;

    logic          port_en_next;
    logic          port_wr_next;
    logic [AD-1:0] port_addr_next;
    logic [C-1:0]  port_din_next;

    logic          serve;
    logic          gnt_a;
    logic          gnt_b;
    logic [1:0]    gnt_vec;
    logic [1:0]    wr_vec;
    logic [1:0]    rvalid_vec;

    assign serve = (state_reg == S_SERVE);

    // Requests are masked during CLEAR so they stay pending without winning.
    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a   (bus.req_a & serve),
        .req_b   (bus.req_b & serve),
        .advance (gnt_a | gnt_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    always_comb begin
        state_next     = state_reg;
        clr_addr_next  = clr_addr_reg;
        port_en_next   = 1'b0;
        port_wr_next   = hold_wr_reg;
        port_addr_next = hold_addr_reg;
        port_din_next  = hold_din_reg;
        case (state_reg)
            S_CLEAR: begin
                port_en_next   = 1'b1;
                port_wr_next   = 1'b1;
                port_addr_next = clr_addr_reg;
                port_din_next  = '0;
                clr_addr_next  = clr_addr_reg + 1'b1;
                if (clr_addr_reg == LAST_ROW) begin
                    state_next = S_SERVE;
                end
            end
            S_SERVE: begin
                if (gnt_a) begin
                    port_en_next   = 1'b1;
                    port_wr_next   = bus.wr_a;
                    port_addr_next = bus.addr_a;
                    port_din_next  = bus.din_a;
                end else if (gnt_b) begin
                    port_en_next   = 1'b1;
                    port_wr_next   = bus.wr_b;
                    port_addr_next = bus.addr_b;
                    port_din_next  = bus.din_b;
                end
            end
            default: begin
                state_next = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_CLEAR;
            clr_addr_reg  <= '0;
            hold_addr_reg <= '0;
            hold_din_reg  <= '0;
            hold_wr_reg   <= 1'b1;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            // Idle cycles replay the last address/data/op on the RAM pins.
            if (port_en_next) begin
                hold_addr_reg <= port_addr_next;
                hold_din_reg  <= port_din_next;
                hold_wr_reg   <= port_wr_next;
            end
        end
    end

    assign gnt_vec = {gnt_b, gnt_a};
    assign wr_vec  = {bus.wr_b, bus.wr_a};

    // Read results are tagged to the side granted one cycle earlier.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
            logic rvalid_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= gnt_vec[gi] & ~wr_vec[gi];
                end
            end
            assign rvalid_vec[gi] = rvalid_reg;
        end
    endgenerate

    assign bus.gnt_a    = gnt_a;
    assign bus.gnt_b    = gnt_b;
    assign bus.rvalid_a = rvalid_vec[0];
    assign bus.rvalid_b = rvalid_vec[1];
    assign bus.rdata    = bus.ram_dout;
    assign bus.busy     = (state_reg == S_CLEAR);
    assign bus.ram_en   = port_en_next;
    assign bus.ram_wr   = port_wr_next;
    assign bus.ram_addr = port_addr_next;
    assign bus.ram_din  = port_din_next;

endmodule
